// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single line-wide memory port between the instruction cache
//   (fetch miss path) and the data cache (memory-stage miss / writeback).
//   One transaction in flight at a time; the returned line and the
//   completion pulse are steered back to whichever cache owns it.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   : round-robin on ties (last-grant bit, reset=I)
//                  undefined : fixed priority, D beats I
//
// Ports:
//   clk, reset                   clock / synchronous active-high reset
//   flush                        fetch flush, kills a pending I response
//   reqI_mem, reqAddrI_mem       I-cache line read request + line address
//   reqD_mem, reqWrD_mem,
//   reqAddrD_mem, wdataD_mem     D-cache request (read or writeback)
//   instr_from_mem, read_ready_I I-side returned line + 1-cycle valid
//   data_from_mem, read_ready_D  D-side returned line + 1-cycle valid
//   written_data_ack_D           1-cycle writeback-complete pulse
//   mem_req/we/addr/wdata        memory request, held until mem_ready
//   mem_ready, mem_rdata         memory completion pulse + read line
//   mem_timeout                  sticky watchdog error
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W   = 26,
    parameter int LINE_W   = 128,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              reqI_mem,
    input  logic [ADDR_W-1:0] reqAddrI_mem,
    input  logic              reqD_mem,
    input  logic              reqWrD_mem,
    input  logic [ADDR_W-1:0] reqAddrD_mem,
    input  logic [LINE_W-1:0] wdataD_mem,
    output logic [LINE_W-1:0] instr_from_mem,
    output logic              read_ready_I,
    output logic [LINE_W-1:0] data_from_mem,
    output logic              read_ready_D,
    output logic              written_data_ack_D,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              mem_timeout
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_kill;
    logic             w_req_i;
    logic             w_pick_d;
    logic             w_wd_expire;

    // A flushed fetch request must not be granted in the flush cycle.
    assign w_req_i     = reqI_mem && !flush;
    assign w_wd_expire = (r_wait_cnt == CNT_W'(MAX_WAIT - 1));

`ifdef MEM_ARB_RR_EN
    // 1 = D was served last. On a tie, the side not served last wins.
    logic r_last_d;
    assign w_pick_d = reqD_mem && !(w_req_i && r_last_d);

    always_ff @(posedge clk) begin
        if (reset)
            r_last_d <= 1'b0;
        else if (mem_ready && r_state == BUSY_D)
            r_last_d <= 1'b1;
        else if (mem_ready && r_state == BUSY_I)
            r_last_d <= 1'b0;
    end
`else
    assign w_pick_d = reqD_mem;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= IDLE;
            r_wait_cnt         <= '0;
            r_kill             <= 1'b0;
            instr_from_mem     <= '0;
            read_ready_I       <= 1'b0;
            data_from_mem      <= '0;
            read_ready_D       <= 1'b0;
            written_data_ack_D <= 1'b0;
            mem_req            <= 1'b0;
            mem_we             <= 1'b0;
            mem_addr           <= '0;
            mem_wdata          <= '0;
            mem_timeout        <= 1'b0;
        end else begin
            read_ready_I       <= 1'b0;
            read_ready_D       <= 1'b0;
            written_data_ack_D <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_kill     <= 1'b0;
                    r_wait_cnt <= '0;
                    if (w_pick_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= reqWrD_mem;
                        mem_addr  <= reqAddrD_mem;
                        mem_wdata <= wdataD_mem;
                        r_state   <= BUSY_D;
                    end else if (w_req_i) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= reqAddrI_mem;
                        r_state  <= BUSY_I;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (r_state == BUSY_I && flush)
                        r_kill <= 1'b1;
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        r_state <= RESP;
                        if (r_state == BUSY_I) begin
                            instr_from_mem <= mem_rdata;
                            // flush in the same cycle as mem_ready also kills
                            read_ready_I   <= !(r_kill || flush);
                        end else if (mem_we) begin
                            written_data_ack_D <= 1'b1;
                        end else begin
                            data_from_mem <= mem_rdata;
                            read_ready_D  <= 1'b1;
                        end
                    end else if (w_wd_expire) begin
                        // Abandon the transaction silently; error stays sticky.
                        mem_timeout <= 1'b1;
                        mem_req     <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    // Requests ignored here so a requester dropping its
                    // request in the pulse cycle is not served twice.
                    r_kill  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int AW = 26;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset, flush;
    logic          reqI_mem, reqD_mem, reqWrD_mem;
    logic [AW-1:0] reqAddrI_mem, reqAddrD_mem;
    logic [LW-1:0] wdataD_mem;
    logic [LW-1:0] instr_from_mem, data_from_mem, mem_wdata, mem_rdata;
    logic          read_ready_I, read_ready_D, written_data_ack_D;
    logic          mem_req, mem_we, mem_ready, mem_timeout;
    logic [AW-1:0] mem_addr;

    int n_chk = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .reqI_mem(reqI_mem), .reqAddrI_mem(reqAddrI_mem),
        .reqD_mem(reqD_mem), .reqWrD_mem(reqWrD_mem),
        .reqAddrD_mem(reqAddrD_mem), .wdataD_mem(wdataD_mem),
        .instr_from_mem(instr_from_mem), .read_ready_I(read_ready_I),
        .data_from_mem(data_from_mem), .read_ready_D(read_ready_D),
        .written_data_ack_D(written_data_ack_D),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req"},   LW'(mem_req), '0);
        chk({tag, ".we"},    LW'(mem_we), '0);
        chk({tag, ".addr"},  LW'(mem_addr), '0);
        chk({tag, ".wdata"}, mem_wdata, '0);
        chk({tag, ".instr"}, instr_from_mem, '0);
        chk({tag, ".data"},  data_from_mem, '0);
        chk({tag, ".pulses"}, LW'({read_ready_I, read_ready_D, written_data_ack_D}), '0);
        chk({tag, ".tmo"},   LW'(mem_timeout), '0);
    endtask

    localparam logic [LW-1:0] L1 = 128'hDEADBEEF_00000000_00000000_00000001;
    localparam logic [LW-1:0] L2 = 128'h22222222_33333333_44444444_55555555;
    localparam logic [LW-1:0] L3 = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
    localparam logic [LW-1:0] L4 = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
    localparam logic [LW-1:0] L6 = 128'h66666666_66666666_66666666_66666666;
    localparam logic [LW-1:0] L7 = 128'h77777777_00000000_77777777_00000000;
    localparam logic [LW-1:0] W1 = 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D;
    localparam logic [LW-1:0] W2 = 128'h99999999_88888888_77777777_66666666;

    logic [AW-1:0] exp_addr [4];

    initial begin
        reset = 1'b1; flush = 1'b0; reqI_mem = 1'b0; reqD_mem = 1'b0;
        reqWrD_mem = 1'b0; reqAddrI_mem = '0; reqAddrD_mem = '0;
        wdataD_mem = '0; mem_ready = 1'b0; mem_rdata = '0;
        tick(); tick();
        chk_all_zero("reset");
        reset = 1'b0;

        // Single I read, ready 5 cycles after mem_req; request held through pulse.
        reqI_mem = 1'b1; reqAddrI_mem = 26'h0000100;
        tick();
        chk("i.req", LW'(mem_req), 1);
        chk("i.addr", LW'(mem_addr), LW'(26'h0000100));
        chk("i.we", LW'(mem_we), 0);
        repeat (4) tick();
        chk("i.req_held", LW'(mem_req), 1);
        mem_ready = 1'b1; mem_rdata = L1;
        tick();
        mem_ready = 1'b0;
        chk("i.req_drop", LW'(mem_req), 0);
        chk("i.rdy", LW'(read_ready_I), 1);
        chk("i.line", instr_from_mem, L1);
        chk("i.rdyD", LW'(read_ready_D), 0);
        tick();                         // RESP: reqI still high, ignored
        chk("held.pulse_end", LW'(read_ready_I), 0);
        chk("held.no_regrant", LW'(mem_req), 0);
        reqI_mem = 1'b0;
        tick();
        chk("held.idle", LW'(mem_req), 0);

        // Contention: D write wins, RESP gap, then I.
        reqI_mem = 1'b1; reqAddrI_mem = 26'h0000300;
        reqD_mem = 1'b1; reqWrD_mem = 1'b1; reqAddrD_mem = 26'h0000200; wdataD_mem = W1;
        tick();
        chk("cont.d_addr", LW'(mem_addr), LW'(26'h0000200));
        chk("cont.d_we", LW'(mem_we), 1);
        chk("cont.d_wdata", mem_wdata, W1);
        mem_ready = 1'b1; mem_rdata = L4;
        tick();
        mem_ready = 1'b0;
        chk("cont.ack", LW'(written_data_ack_D), 1);
        chk("cont.no_rdD", LW'(read_ready_D), 0);
        chk("cont.data_hold", data_from_mem, '0);
        reqD_mem = 1'b0; reqWrD_mem = 1'b0;
        tick();
        chk("cont.gap", LW'(mem_req), 0);
        tick();
        chk("cont.i_req", LW'(mem_req), 1);
        chk("cont.i_addr", LW'(mem_addr), LW'(26'h0000300));
        chk("cont.i_we", LW'(mem_we), 0);
        mem_ready = 1'b1; mem_rdata = L2;
        tick();
        mem_ready = 1'b0;
        chk("cont.i_rdy", LW'(read_ready_I), 1);
        chk("cont.i_line", instr_from_mem, L2);
        reqI_mem = 1'b0;
        tick(); tick();

        // Flush 2 cycles after I grant kills the response.
        reqI_mem = 1'b1; reqAddrI_mem = 26'h0000400;
        tick();
        chk("fl.req", LW'(mem_req), 1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl.req_held", LW'(mem_req), 1);
        mem_ready = 1'b1; mem_rdata = L3;
        tick();
        mem_ready = 1'b0; reqI_mem = 1'b0;
        chk("fl.no_rdy", LW'(read_ready_I), 0);
        chk("fl.req_drop", LW'(mem_req), 0);
        // Back in IDLE 2 cycles after mem_ready: a D read arriving in RESP is
        // granted at the following edge.
        reqD_mem = 1'b1; reqAddrD_mem = 26'h0000500;
        tick();
        chk("fl.resp_ignore", LW'(mem_req), 0);
        tick();
        chk("fl.idle_grant", LW'(mem_req), 1);
        chk("fl.d_addr", LW'(mem_addr), LW'(26'h0000500));
        flush = 1'b1;                   // no effect on D
        mem_ready = 1'b1; mem_rdata = L4;
        tick();
        flush = 1'b0; mem_ready = 1'b0; reqD_mem = 1'b0;
        chk("fl.d_rdy", LW'(read_ready_D), 1);
        chk("fl.d_line", data_from_mem, L4);
        tick(); tick();

        // mem_ready together with flush in BUSY_I: suppressed.
        reqI_mem = 1'b1; reqAddrI_mem = 26'h0000600;
        tick();
        mem_ready = 1'b1; flush = 1'b1; mem_rdata = L3;
        tick();
        mem_ready = 1'b0; flush = 1'b0; reqI_mem = 1'b0;
        chk("flr.no_rdy", LW'(read_ready_I), 0);
        tick(); tick();

        // Kill flag gone: next I read responds.
        reqI_mem = 1'b1; reqAddrI_mem = 26'h0000700;
        tick();
        mem_ready = 1'b1; mem_rdata = L6;
        tick();
        mem_ready = 1'b0; reqI_mem = 1'b0;
        chk("kc.rdy", LW'(read_ready_I), 1);
        chk("kc.line", instr_from_mem, L6);
        tick(); tick();

        // Flush in IDLE blocks the I grant for that cycle.
        reqI_mem = 1'b1; flush = 1'b1; reqAddrI_mem = 26'h0000710;
        tick();
        chk("fi.blocked", LW'(mem_req), 0);
        flush = 1'b0;
        tick();
        chk("fi.granted", LW'(mem_req), 1);
        mem_ready = 1'b1; mem_rdata = L6;
        tick();
        mem_ready = 1'b0; reqI_mem = 1'b0;
        tick(); tick();

        // Stray mem_ready in IDLE.
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("stray.pulses", LW'({read_ready_I, read_ready_D, written_data_ack_D}), 0);

        // Watchdog with MAX_WAIT=8.
        reqD_mem = 1'b1; reqWrD_mem = 1'b0; reqAddrD_mem = 26'h0000800;
        tick();
        chk("wd.req", LW'(mem_req), 1);
        repeat (7) tick();
        chk("wd.not_yet", LW'(mem_timeout), 0);
        chk("wd.req7", LW'(mem_req), 1);
        tick();
        chk("wd.tmo", LW'(mem_timeout), 1);
        chk("wd.req_drop", LW'(mem_req), 0);
        chk("wd.no_pulse", LW'(read_ready_D), 0);
        tick();
        chk("wd.regrant", LW'(mem_req), 1);
        chk("wd.addr", LW'(mem_addr), LW'(26'h0000800));
        mem_ready = 1'b1; mem_rdata = L7;
        tick();
        mem_ready = 1'b0; reqD_mem = 1'b0;
        chk("wd.d_rdy", LW'(read_ready_D), 1);
        chk("wd.d_line", data_from_mem, L7);
        chk("wd.sticky", LW'(mem_timeout), 1);
        tick(); tick();

        // Tie rounds from reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("tie.tmo_clr", LW'(mem_timeout), 0);
`ifdef MEM_ARB_RR_EN
        exp_addr = '{26'h0000A00, 26'h0000B00, 26'h0000A00, 26'h0000B00};
`else
        exp_addr = '{26'h0000A00, 26'h0000A00, 26'h0000A00, 26'h0000A00};
`endif
        for (int r = 0; r < 4; r++) begin
            reqD_mem = 1'b1; reqWrD_mem = 1'b0; reqAddrD_mem = 26'h0000A00;
            reqI_mem = 1'b1; reqAddrI_mem = 26'h0000B00;
            tick();
            chk($sformatf("tie%0d.addr", r), LW'(mem_addr), LW'(exp_addr[r]));
            mem_ready = 1'b1; mem_rdata = L2;
            tick();
            mem_ready = 1'b0; reqD_mem = 1'b0; reqI_mem = 1'b0;
            tick(); tick();
        end

        // Reset mid-BUSY_D write.
        reqD_mem = 1'b1; reqWrD_mem = 1'b1; reqAddrD_mem = 26'h0000900; wdataD_mem = W2;
        tick();
        chk("rst.busy", LW'(mem_req), 1);
        reqD_mem = 1'b0; reqWrD_mem = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("rst_mid");
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("rst.no_ack", LW'(written_data_ack_D), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
